uart_rx: RTL and testbench

- UART receiver for the SoC's host-to-target serial line, driven from the top-level `uart_tx_in` pin.
- It is the receive-direction counterpart to the existing UART transmitter that drives `uart_rx_out`.
- Decodes 8N1 frames using 16x oversampling, buffers received bytes in a small FIFO, and presents them on a valid/ready read interface to the peripheral bus slave.
- Reports framing and overrun errors as sticky flags.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_if.sv | 12 +
 rtl/sync_fifo.sv | 69 ++++++
 rtl/uart_rx.sv | 169 ++++++++++++++++
 tb/tb_uart_rx.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS  = 8;

  localparam int SAMP_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(MID_SAMPLE);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - valid/ready byte read interface of the UART receiver
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rdata;
  logic                 rvalid;
  logic                 rready;

  modport master (output rdata, output rvalid, input rready);
  modport slave  (input rdata, input rvalid, output rready);

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through synchronous FIFO, power-of-two depth
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted then.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 16x oversampling, byte FIFO and sticky errors
module uart_rx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        rx_i,
  input  logic                        en_i,
  input  logic [DIV_W-1:0]            baud_div_i,
  uart_rx_if.master                   rd,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic                        frame_err_o,
  output logic                        overrun_o,
  input  logic                        clr_err_i
);

  logic [1:0]           sync_q, sync_d;
  logic                 rx_s;
  uart_rx_state_e       state_q, state_d;
  logic [DIV_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [SAMP_W-1:0]    samp_q, samp_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 tick;
  logic                 push;
  logic                 frame_set;
  logic                 fifo_full, fifo_empty;

  assign sync_d = {sync_q[0], rx_i};
  assign rx_s   = sync_q[1];
  assign tick   = (state_q != ST_IDLE) && (tick_cnt_q == div_q);

  // The divisor is sampled only at a wrap (or while idle) so a change never shortens a tick.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    div_d      = div_q;
    if (!en_i || state_q == ST_IDLE || tick) begin
      tick_cnt_d = '0;
      div_d      = baud_div_i;
    end else begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    samp_d    = samp_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          samp_d  = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (samp_q == SAMP_MID) begin
            samp_d  = '0;
            bit_d   = '0;
            state_d = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (samp_q == SAMP_LAST) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            samp_d  = '0;
            bit_d   = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
              state_d = ST_STOP;
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (samp_q == SAMP_LAST) begin
            samp_d = '0;
            if (rx_s) begin
              push    = 1'b1;
              state_d = ST_IDLE;
            end else begin
              frame_set = 1'b1;
              state_d   = ST_WAIT_HIGH;
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!en_i) begin
      state_d   = ST_IDLE;
      push      = 1'b0;
      frame_set = 1'b0;
    end
  end

  // Set wins over clear; a full FIFO with a concurrent pop is not an overrun.
  always_comb begin
    frame_err_d = frame_set | (frame_err_q & ~clr_err_i);
    overrun_d   = (push && fifo_full && !rd.rready) | (overrun_q & ~clr_err_i);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q      <= 2'b11;
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      div_q       <= '0;
      samp_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      div_q       <= div_d;
      samp_q      <= samp_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push),
    .wdata_i (shift_d),
    .pop_i   (rd.rready),
    .rdata_o (rd.rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

  assign rd.rvalid   = !fifo_empty;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a queue model
module tb_uart_rx;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx;
  logic        en;
  logic [15:0] baud_div;
  logic [3:0]  fifo_count;
  logic        frame_err;
  logic        overrun;
  logic        clr_err;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q[$];
  logic        exp_ferr;
  logic        exp_ovr;
  logic [7:0]  b;

  uart_rx_if rd_if ();

  uart_rx #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .rx_i         (rx),
    .en_i         (en),
    .baud_div_i   (baud_div),
    .rd           (rd_if),
    .fifo_count_o (fifo_count),
    .frame_err_o  (frame_err),
    .overrun_o    (overrun),
    .clr_err_i    (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference FIFO: accept while space remains, otherwise record an overrun.
  task automatic model_push(input logic [7:0] v);
    if (exp_q.size() < DEPTH) exp_q.push_back(v);
    else exp_ovr = 1'b1;
  endtask

  // Called on a falling clock edge; the start bit begins immediately.
  task automatic send_frame(input logic [7:0] v, input logic stop, input int div);
    int bp;
    bp = 16 * (div + 1);
    rx = 1'b0;
    repeat (bp) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      repeat (bp) @(negedge clk);
    end
    rx = stop;
    repeat (bp) @(negedge clk);
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_count"}, 32'(fifo_count), 32'(exp_q.size()));
    chk({tag, "_frame_err"}, 32'(frame_err), 32'(exp_ferr));
    chk({tag, "_overrun"}, 32'(overrun), 32'(exp_ovr));
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      chk({tag, "_rvalid"}, 32'(rd_if.rvalid), 32'd1);
      chk({tag, "_rdata"}, 32'(rd_if.rdata), 32'(exp_q.pop_front()));
      rd_if.rready = 1'b1;
      @(negedge clk);
      rd_if.rready = 1'b0;
    end
    chk({tag, "_empty_rvalid"}, 32'(rd_if.rvalid), 32'd0);
    chk({tag, "_empty_count"}, 32'(fifo_count), 32'd0);
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    rx = 1'b1;
    en = 1'b1;
    baud_div = 16'd0;
    clr_err = 1'b0;
    rd_if.rready = 1'b0;
    exp_ferr = 1'b0;
    exp_ovr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rvalid", 32'(rd_if.rvalid), 32'd0);
    chk("reset_rdata", 32'(rd_if.rdata), 32'd0);
    check_flags("reset");
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // 0xA5: 2 sync + 1 detect + 8 ticks to mid start + 9*16 ticks to mid stop = push at edge 155.
    fork
      send_frame(8'hA5, 1'b1, 0);
      begin
        repeat (154) @(posedge clk);
        #1 chk("t1_before_push_rvalid", 32'(rd_if.rvalid), 32'd0);
        @(posedge clk);
        #1 chk("t1_latency_rvalid", 32'(rd_if.rvalid), 32'd1);
        chk("t1_latency_rdata", 32'(rd_if.rdata), 32'hA5);
      end
    join
    model_push(8'hA5);
    check_flags("t1");
    drain("t1");
    check_flags("t1_after");

    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check_flags("t2_glitch");
    send_frame(8'h3C, 1'b1, 0);
    model_push(8'h3C);
    drain("t2");

    send_frame(8'h55, 1'b0, 0);
    exp_ferr = 1'b1;
    repeat (640) @(negedge clk);
    check_flags("t3_break");
    rx = 1'b1;
    repeat (32) @(negedge clk);
    send_frame(8'h12, 1'b1, 0);
    model_push(8'h12);
    check_flags("t3_after_release");
    drain("t3");
    clear_errors();
    check_flags("t3_cleared");

    for (int i = 0; i < 9; i++) begin
      send_frame(8'(i), 1'b1, 0);
      model_push(8'(i));
    end
    check_flags("t4_full");
    drain("t4");
    clear_errors();
    check_flags("t4_cleared");

    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 0);
      model_push(b);
    end
    check_flags("t5_full");
    fork
      send_frame(8'h77, 1'b1, 0);
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        rd_if.rready = 1'b1;
        @(negedge clk);
        rd_if.rready = 1'b0;
      end
    join
    void'(exp_q.pop_front());
    exp_q.push_back(8'h77);
    check_flags("t5_simul");
    drain("t5");

    fork
      send_frame(8'hF0, 1'b1, 0);
      begin
        repeat (16 * 3 + 8 + 3) @(negedge clk);
        en = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    check_flags("t6_aborted");
    en = 1'b1;
    baud_div = 16'd3;
    repeat (4) @(negedge clk);
    send_frame(8'h81, 1'b1, 3);
    model_push(8'h81);
    check_flags("t6_rx");
    drain("t6");

    for (int i = 0; i < 10; i++) begin
      int div;
      div = int'($urandom_range(0, 3));
      baud_div = 16'(div);
      b = 8'($urandom);
      send_frame(b, 1'b1, div);
      model_push(b);
      check_flags("rand");
      if ($urandom_range(0, 2) == 0) drain("rand");
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    drain("rand_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
